// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter: read-side consumer turning an async FIFO pull port into a valid/ready stream
//
// Ports (all in the rclock domain):
//   rclock         read-domain clock, rising edge
//   rreset         asynchronous active-low reset
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid one cycle after fifo_r_en
//   fifo_r_en      FIFO read enable
//   flush          synchronous clear of the local buffer and any in-flight read
//   m_valid/m_ready/m_data  output stream
//   occupancy      words held in the local buffer
// Optional: define FIFO_RD_STATS_EN to add rd_count (pops) and stall_count
// (cycles with m_valid & !m_ready), both cleared only by rreset.
module fifo_read_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                        rclock,
    input  logic                        rreset,
    input  logic                        fifo_empty,
    input  logic [DATA_WIDTH-1:0]       fifo_data_out,
    output logic                        fifo_r_en,
    input  logic                        flush,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic [$clog2(BUF_DEPTH):0]  occupancy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]                 rd_count,
    output logic [31:0]                 stall_count
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(BUF_DEPTH);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  rd_pend, pop, push;
    logic [AW+1:0]         credit;
    // credit counts buffered words plus the read already in flight, minus the
    // word leaving this cycle; m_ready feeds fifo_r_en combinationally so a
    // two-entry buffer can still sustain one word per cycle.
    always_comb begin
        m_valid   = count != '0;
        pop       = m_valid & m_ready;
        push      = rd_pend & !flush;
        credit    = {1'b0, count} + (AW+2)'(rd_pend) - (AW+2)'(pop);
        fifo_r_en = !flush & !fifo_empty & (credit < {1'b0, FULL});
    end
    assign m_data    = mem[rd_ptr];
    assign occupancy = count;
    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            rd_pend <= fifo_r_en;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= fifo_data_out;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    // The read credit must make a push into a full buffer impossible.
    assert property (@(posedge rclock) disable iff (!rreset) !(push && !pop && count == FULL));
`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rclock or negedge rreset) begin
        if (!rreset) begin
            rd_count    <= '0;
            stall_count <= '0;
        end else begin
            if (pop) rd_count <= rd_count + 32'd1;
            if (m_valid & !m_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_read_adapter.sv
// tb_fifo_read_adapter: self-checking bench for fifo_read_adapter with a FIFO source model and scoreboard
module tb_fifo_read_adapter;
    logic       rclock = 1'b0;
    logic       rreset = 1'b1;
    logic       starve = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_r_en;
    logic       flush = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] occupancy;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] rd_count, stall_count;
`endif
    logic [7:0] src_mem [256];
    int         src_wr = 0;
    int         src_rd = 0;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       starve, rdy, fl, e_valid, e_ren;
        logic [1:0] e_occ;
        logic [7:0] e_data;
    } vec_t;
    vec_t tbl [9];

    fifo_read_adapter #(.DATA_WIDTH(8), .BUF_DEPTH(2)) dut (
        .rclock(rclock), .rreset(rreset), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_r_en(fifo_r_en), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy)
`ifdef FIFO_RD_STATS_EN
        , .rd_count(rd_count), .stall_count(stall_count)
`endif
    );

    always #5 rclock = ~rclock;

    // Source FIFO model: registered read, data one cycle after fifo_r_en.
    assign fifo_empty = starve | (src_rd == src_wr);
    always @(posedge rclock) begin
        if (fifo_r_en) begin
            fifo_data_out <= src_mem[src_rd % 256];
            src_rd        <= src_rd + 1;
        end
    end

    function automatic vec_t mk(input logic [4:0] b, input logic [1:0] o, input logic [7:0] d);
        vec_t v;
        v.starve = b[4]; v.rdy = b[3]; v.fl = b[2]; v.e_valid = b[1]; v.e_ren = b[0];
        v.e_occ = o; v.e_data = d;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    task automatic load(input logic [7:0] w, input bit keep);
        src_mem[src_wr % 256] = w;
        src_wr++;
        if (keep) exp_q.push_back(w);
    endtask

    // Sample phase: scoreboard checks every word the sink accepts at the next edge.
    task automatic samp();
        logic [7:0] w;
        @(negedge rclock);
        if (rreset && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got %0h want none", m_data);
            end else begin
                w = exp_q.pop_front();
                if (m_data !== w) begin
                    errors++;
                    $display("FAIL sb_data got %0h want %0h", m_data, w);
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge rclock);
        #1;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) begin
            samp();
            adv();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle_chk(input string n);
        chk({n, "_valid"}, 32'(m_valid), 32'd0);
        chk({n, "_ren"}, 32'(fifo_r_en), 32'd0);
        chk({n, "_occ"}, 32'(occupancy), 32'd0);
        chk({n, "_data"}, 32'(m_data), 32'd0);
    endtask

    task automatic do_reset();
        rreset = 1'b0; flush = 1'b0; m_ready = 1'b0; starve = 1'b1;
        exp_q.delete();
        repeat (5) begin
            samp();
            idle_chk("rst");
`ifdef FIFO_RD_STATS_EN
            chk("rst_rdcnt", rd_count, 32'd0);
            chk("rst_stall", stall_count, 32'd0);
`endif
            adv();
        end
        rreset = 1'b1;
        repeat (2) begin
            samp();
            idle_chk("post_rst");
            adv();
        end
    endtask

    initial begin
        int n, ren_n, ren_f, ren_l, v_n, v_f, v_l;
        adv();
        do_reset();

        // Table: cycle-by-cycle credit, flush and empty gating with words 0x40..0x43.
        tbl[0] = mk(5'b10000, 2'd0, 8'h00);
        tbl[1] = mk(5'b00100, 2'd0, 8'h00);
        tbl[2] = mk(5'b00001, 2'd0, 8'h00);
        tbl[3] = mk(5'b00001, 2'd0, 8'h00);
        tbl[4] = mk(5'b00010, 2'd1, 8'h40);
        tbl[5] = mk(5'b00010, 2'd2, 8'h40);
        tbl[6] = mk(5'b01011, 2'd2, 8'h40);
        tbl[7] = mk(5'b00010, 2'd1, 8'h41);
        tbl[8] = mk(5'b01011, 2'd2, 8'h41);
        for (int i = 0; i < 4; i++) load(8'h40 + 8'(i), 1'b1);
        for (int i = 0; i < 9; i++) begin
            starve = tbl[i].starve; m_ready = tbl[i].rdy; flush = tbl[i].fl;
            samp();
            chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ren", i), 32'(fifo_r_en), 32'(tbl[i].e_ren));
            chk($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].e_data));
            adv();
        end
        flush = 1'b0; starve = 1'b0; m_ready = 1'b1;
        drain(20);

        // Single word: latency c -> c+2, valid for exactly one cycle.
        load(8'hA5, 1'b1);
        n = 0;
        samp();
        while (!fifo_r_en && n < 8) begin adv(); samp(); n++; end
        chk("single_ren_c", 32'(fifo_r_en), 32'd1);
        chk("single_valid_c", 32'(m_valid), 32'd0);
        adv(); samp();
        chk("single_ren_c1", 32'(fifo_r_en), 32'd0);
        chk("single_valid_c1", 32'(m_valid), 32'd0);
        adv(); samp();
        chk("single_valid_c2", 32'(m_valid), 32'd1);
        chk("single_data_c2", 32'(m_data), 32'hA5);
        adv(); samp();
        chk("single_valid_c3", 32'(m_valid), 32'd0);
        chk("single_occ_c3", 32'(occupancy), 32'd0);
        adv();

        // Streaming 32 words with m_ready held high.
        for (int i = 0; i < 32; i++) load(8'(i), 1'b1);
        ren_n = 0; ren_f = -1; ren_l = -1; v_n = 0; v_f = -1; v_l = -1;
        for (int i = 0; i < 60; i++) begin
            samp();
            if (fifo_r_en) begin if (ren_f < 0) ren_f = i; ren_l = i; ren_n++; end
            if (m_valid) begin if (v_f < 0) v_f = i; v_l = i; v_n++; end
            adv();
        end
        chk("stream_ren_n", 32'(ren_n), 32'd32);
        chk("stream_ren_span", 32'(ren_l - ren_f), 32'd31);
        chk("stream_valid_n", 32'(v_n), 32'd32);
        chk("stream_valid_span", 32'(v_l - v_f), 32'd31);
        chk("stream_left", 32'(exp_q.size()), 32'd0);

        // Backpressure: only BUF_DEPTH reads while the sink stalls.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(8'h60 + 8'(i), 1'b1);
        ren_n = 0;
        repeat (6) begin
            samp();
            if (fifo_r_en) ren_n++;
            adv();
        end
        chk("bp_ren_n", 32'(ren_n), 32'd2);
        samp();
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", 32'(m_data), 32'h60);
        adv();
        m_ready = 1'b1;
        drain(40);

        // Flush with a read in flight: 0x11 buffered, 0x22 in flight, both dropped.
        m_ready = 1'b0;
        load(8'h11, 1'b0);
        n = 0;
        samp();
        while (occupancy != 2'd1 && n < 10) begin adv(); samp(); n++; end
        chk("fl_occ_pre", 32'(occupancy), 32'd1);
        adv();
        load(8'h22, 1'b0);
        samp();
        chk("fl_ren_issue", 32'(fifo_r_en), 32'd1);
        adv();
        flush = 1'b1;
        samp();
        chk("fl_ren_held", 32'(fifo_r_en), 32'd0);
        adv();
        flush = 1'b0;
        samp();
        chk("fl_valid_after", 32'(m_valid), 32'd0);
        chk("fl_occ_after", 32'(occupancy), 32'd0);
        adv();
        load(8'h33, 1'b1);
        m_ready = 1'b1;
        drain(20);
        repeat (3) begin samp(); adv(); end

`ifdef FIFO_RD_STATS_EN
        // Counters: 10 pops with 4 stall cycles; flush keeps them, reset clears them.
        do_reset();
        starve = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 10; i++) load(8'h80 + 8'(i), 1'b1);
        n = 0;
        samp();
        while (!m_valid && n < 10) begin adv(); samp(); n++; end
        adv();
        m_ready = 1'b0;
        repeat (4) begin samp(); adv(); end
        m_ready = 1'b1;
        drain(40);
        samp();
        chk("st_rdcnt", rd_count, 32'd10);
        chk("st_stall", stall_count, 32'd4);
        adv();
        flush = 1'b1;
        samp(); adv();
        flush = 1'b0;
        samp();
        chk("st_rdcnt_flush", rd_count, 32'd10);
        chk("st_stall_flush", stall_count, 32'd4);
        adv();
        rreset = 1'b0;
        samp();
        chk("st_rdcnt_rst", rd_count, 32'd0);
        chk("st_stall_rst", stall_count, 32'd0);
        adv();
        rreset = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
